// File: rtl/alu_issue_if.sv
// Issue / ALU / result / debug signal bundle for alu_issue_ctrl.
// The slave side is the sequencer; the master side is the upstream issuer plus the ALU.
interface alu_issue_if;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 3;
    localparam int unsigned FW = 3;

    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_op;
    logic [AW-1:0] in_rd;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic          in_imm_en;
    logic [DW-1:0] in_imm;

    logic [FW-1:0] alu_f;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_r;

    logic          out_valid;
    logic [AW-1:0] out_rd;
    logic [DW-1:0] out_data;
    logic          out_zero;
    logic          out_neg;

    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
        output alu_r, dbg_addr,
        input  in_ready, alu_f, alu_a, alu_b,
        input  out_valid, out_rd, out_data, out_zero, out_neg, dbg_data
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
        input  alu_r, dbg_addr,
        output in_ready, alu_f, alu_a, alu_b,
        output out_valid, out_rd, out_data, out_zero, out_neg, dbg_data
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue sequencer in front of a combinational 32-bit ALU: reads an 8x32
// register file, drives F/A/B, captures R and writes it back with zero/neg flags.
module alu_issue_ctrl (
    input  logic       clk,
    input  logic       rst,
    alu_issue_if.slave bus
);
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 3;
    localparam int unsigned FW   = 3;
    localparam int unsigned NREG = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

    typedef struct packed {
        logic [FW-1:0] op;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          imm_en;
        logic [DW-1:0] imm;
    } instr_t;

    state_e        state_q, state_d;
    logic          ready_c;
    logic          valid_c;
    logic          accept_c;
    logic          wb_en_c;

    instr_t        instr_q, instr_d;
    logic [DW-1:0] rf_q [NREG];

    logic [FW-1:0] alu_f_q, alu_f_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;

    logic [AW-1:0] out_rd_q, out_rd_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_zero_q, out_zero_d;
    logic          out_neg_q, out_neg_d;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one instruction walks READ -> EXEC -> WB; WB may take the next one
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept_c) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = accept_c ? READ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: ready is suppressed while reset is asserted so a coincident offer is dropped
    always_comb begin
        ready_c = 1'b0;
        valid_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_c = ~rst;
            end
            WB: begin
                ready_c = ~rst;
                valid_c = 1'b1;
            end
            default: begin
                ready_c = 1'b0;
                valid_c = 1'b0;
            end
        endcase
    end

    assign accept_c = bus.in_valid & ready_c;
    assign wb_en_c  = (state_q == WB) && (out_rd_q != '0);

    // Datapath next values; everything holds unless its stage is active
    always_comb begin
        instr_d    = instr_q;
        alu_f_d    = alu_f_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        out_rd_d   = out_rd_q;
        out_data_d = out_data_q;
        out_zero_d = out_zero_q;
        out_neg_d  = out_neg_q;

        if (accept_c) begin
            instr_d = '{op:     bus.in_op,
                        rd:     bus.in_rd,
                        rs1:    bus.in_rs1,
                        rs2:    bus.in_rs2,
                        imm_en: bus.in_imm_en,
                        imm:    bus.in_imm};
        end

        if (state_q == READ) begin
            alu_f_d = instr_q.op;
            alu_a_d = instr_q.imm_en ? instr_q.imm : rf_q[instr_q.rs1];
            alu_b_d = rf_q[instr_q.rs2];
        end

        if (state_q == EXEC) begin
            out_data_d = bus.alu_r;
            out_rd_d   = instr_q.rd;
            out_zero_d = (bus.alu_r == '0);
            out_neg_d  = bus.alu_r[DW-1];
        end
    end

    // Datapath registers; r0 is never written so it always reads as zero
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= '0;
            alu_f_q    <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            out_rd_q   <= '0;
            out_data_q <= '0;
            out_zero_q <= 1'b0;
            out_neg_q  <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[AW'(i)] <= '0;
            end
        end else begin
            instr_q    <= instr_d;
            alu_f_q    <= alu_f_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            out_rd_q   <= out_rd_d;
            out_data_q <= out_data_d;
            out_zero_q <= out_zero_d;
            out_neg_q  <= out_neg_d;
            if (wb_en_c) begin
                rf_q[out_rd_q] <= out_data_q;
            end
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = valid_c;
    assign bus.alu_f     = alu_f_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_neg   = out_neg_q;
    assign bus.dbg_data  = rf_q[bus.dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: combinational ALU, cycle-numbered reference model, per-cycle compare,
// and directed instructions with hand-computed results.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_if bus ();

    alu_issue_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] alu_fn(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return ~(a ^ b);
            3'd5:    return ~a;
            3'd6:    return a;
            default: return ~b;
        endcase
    endfunction

    always_comb bus.alu_r = alu_fn(bus.alu_f, bus.alu_a, bus.alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: instruction accepted at edge A has operands at A+1,
    // result at A+2 (strobe cycle), register write at A+3.
    int          e_cnt = 0;
    bit          m_init = 1'b0;
    bit          have = 1'b0;
    int          acc = 0;
    logic [31:0] m_rf [8];
    logic [2:0]  m_op, m_rd, m_rs1, m_rs2;
    logic        m_imm_en;
    logic [31:0] m_imm;
    logic [2:0]  exp_f, exp_rd;
    logic [31:0] exp_a, exp_b, exp_data;
    logic        exp_zero, exp_neg;

    always @(posedge clk) begin
        bit rdy;
        e_cnt++;
        if (rst) begin
            m_init = 1'b1;
            have   = 1'b0;
            for (int i = 0; i < 8; i++) m_rf[i] = '0;
            exp_f = '0; exp_a = '0; exp_b = '0;
            exp_rd = '0; exp_data = '0; exp_zero = 1'b0; exp_neg = 1'b0;
        end else if (m_init) begin
            rdy = !have || (e_cnt >= acc + 3);
            if (have && e_cnt == acc + 1) begin
                exp_f = m_op;
                exp_a = m_imm_en ? m_imm : m_rf[m_rs1];
                exp_b = m_rf[m_rs2];
            end
            if (have && e_cnt == acc + 2) begin
                exp_data = alu_fn(exp_f, exp_a, exp_b);
                exp_rd   = m_rd;
                exp_zero = (exp_data == 32'd0);
                exp_neg  = exp_data[31];
            end
            if (have && e_cnt == acc + 3) begin
                if (exp_rd != 3'd0) m_rf[exp_rd] = exp_data;
                have = 1'b0;
            end
            if (bus.in_valid && rdy) begin
                m_op = bus.in_op; m_rd = bus.in_rd; m_rs1 = bus.in_rs1; m_rs2 = bus.in_rs2;
                m_imm_en = bus.in_imm_en; m_imm = bus.in_imm;
                acc  = e_cnt;
                have = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready",  32'(bus.in_ready),  32'(!rst && (!have || e_cnt >= acc + 2)));
            chk("out_valid", 32'(bus.out_valid), 32'(have && e_cnt == acc + 2));
            chk("alu_f",     32'(bus.alu_f),     32'(exp_f));
            chk("alu_a",     bus.alu_a,          exp_a);
            chk("alu_b",     bus.alu_b,          exp_b);
            chk("out_rd",    32'(bus.out_rd),    32'(exp_rd));
            chk("out_data",  bus.out_data,       exp_data);
            chk("out_zero",  32'(bus.out_zero),  32'(exp_zero));
            chk("out_neg",   32'(bus.out_neg),   32'(exp_neg));
            chk("dbg_data",  bus.dbg_data,       m_rf[bus.dbg_addr]);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic imm_en, input logic [31:0] imm,
                         output int acc_edge);
        int n;
        @(posedge clk); #1;
        bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_imm_en = imm_en; bus.in_imm = imm;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            tests++; fails++;
            $display("FAIL issue_timeout: in_ready low for %0d cycles, expected high", n);
        end
        @(posedge clk); #1;
        acc_edge = e_cnt;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input int acc_edge, input logic [2:0] rd,
                               input logic [31:0] data, input logic zero, input logic neg);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 12);
        if (!bus.out_valid) begin
            tests++; fails++;
            $display("FAIL %s_timeout: out_valid low, expected a strobe", name);
        end else begin
            chk({name, "_latency"}, 32'(e_cnt - acc_edge), 32'd2);
            chk({name, "_rd"},      32'(bus.out_rd),   32'(rd));
            chk({name, "_data"},    bus.out_data,      data);
            chk({name, "_zero"},    32'(bus.out_zero), 32'(zero));
            chk({name, "_neg"},     32'(bus.out_neg),  32'(neg));
        end
    endtask

    task automatic check_reg(input string name, input logic [2:0] addr, input logic [31:0] exp);
        @(posedge clk); #1;
        bus.dbg_addr = addr;
        #1;
        chk(name, bus.dbg_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
        bus.in_imm_en = 1'b0; bus.in_imm = '0; bus.dbg_addr = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.in_ready),  32'd1);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_alu_f", 32'(bus.alu_f),     32'd0);
        chk("rst_alu_a", bus.alu_a,          32'd0);
        chk("rst_alu_b", bus.alu_b,          32'd0);
        for (int i = 0; i < 8; i++) check_reg("rst_rf", 3'(i), 32'd0);

        // immediate loads
        issue(3'd6, 3'd1, 3'd0, 3'd0, 1'b1, 32'h0000_0005, a0);
        wait_result("ld_r1", a0, 3'd1, 32'h0000_0005, 1'b0, 1'b0);
        check_reg("r1", 3'd1, 32'h0000_0005);
        issue(3'd6, 3'd2, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFD, a0);
        wait_result("ld_r2", a0, 3'd2, 32'hFFFF_FFFD, 1'b0, 1'b1);
        check_reg("r2", 3'd2, 32'hFFFF_FFFD);

        // back-to-back dependent pair, second accepted in WB of the first
        issue(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0, a1);
        issue(3'd1, 3'd4, 3'd3, 3'd1, 1'b0, 32'd0, a2);
        chk("b2b_gap", 32'(a2 - a1), 32'd3);
        wait_result("sub_r4", a2, 3'd4, 32'hFFFF_FFFD, 1'b0, 1'b1);
        check_reg("r3", 3'd3, 32'h0000_0002);
        check_reg("r4", 3'd4, 32'hFFFF_FFFD);

        // logic ops and flags
        issue(3'd4, 3'd5, 3'd1, 3'd1, 1'b0, 32'd0, a0);
        wait_result("xnor_r5", a0, 3'd5, 32'hFFFF_FFFF, 1'b0, 1'b1);
        issue(3'd2, 3'd6, 3'd1, 3'd0, 1'b0, 32'd0, a0);
        wait_result("and_r6", a0, 3'd6, 32'h0000_0000, 1'b1, 1'b0);
        issue(3'd7, 3'd7, 3'd0, 3'd0, 1'b0, 32'd0, a0);
        wait_result("notb_r7", a0, 3'd7, 32'hFFFF_FFFF, 1'b0, 1'b1);
        issue(3'd3, 3'd6, 3'd1, 3'd2, 1'b0, 32'd0, a0);
        wait_result("or_r6", a0, 3'd6, 32'hFFFF_FFFD, 1'b0, 1'b1);
        issue(3'd1, 3'd6, 3'd0, 3'd1, 1'b1, 32'h0000_0010, a0);
        wait_result("subimm_r6", a0, 3'd6, 32'h0000_000B, 1'b0, 1'b0);
        issue(3'd5, 3'd5, 3'd2, 3'd0, 1'b0, 32'd0, a0);
        wait_result("nota_r5", a0, 3'd5, 32'h0000_0002, 1'b0, 1'b0);
        check_reg("r5", 3'd5, 32'h0000_0002);
        check_reg("r7", 3'd7, 32'hFFFF_FFFF);

        // r0 stays zero
        issue(3'd6, 3'd0, 3'd0, 3'd0, 1'b1, 32'h0000_1234, a0);
        wait_result("ld_r0", a0, 3'd0, 32'h0000_1234, 1'b0, 1'b0);
        check_reg("r0", 3'd0, 32'h0000_0000);

        // reset while in EXEC, with an offer coincident with reset
        issue(3'd6, 3'd3, 3'd0, 3'd0, 1'b1, 32'h0000_0077, a0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.in_ready),  32'd1);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
        repeat (5) @(posedge clk);
        check_reg("r3_after_rst", 3'd3, 32'h0000_0000);
        check_reg("r1_after_rst", 3'd1, 32'h0000_0000);

        // still operational after reset
        issue(3'd6, 3'd3, 3'd0, 3'd0, 1'b1, 32'h8000_0000, a0);
        wait_result("ld_r3_post", a0, 3'd3, 32'h8000_0000, 1'b0, 1'b1);
        check_reg("r3_post", 3'd3, 32'h8000_0000);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencer that sits directly upstream of the 32-bit ALU, with its 3-bit function select: 000 add, 001 sub, 010 and, 011 or, 100 xnor, 101 not A, 110 pass A, 111 not B. It holds an 8×32 register file and accepts one instruction at a time over a valid/ready handshake. It reads operands and drives the ALU's F/A/B inputs from registers, captures R, and writes the result back with zero/negative flags. The ALU stays purely combinational; every stage boundary here is registered.

## Interface
- No parameters. Register count fixed at 8 (r0..r7); data width fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  block can accept this cycle
- in_op  in  3  ALU function code (F encoding above)
- in_rd  in  3  destination register
- in_rs1  in  3  A-operand register
- in_rs2  in  3  B-operand register
- in_imm_en  in  1  1: A operand = in_imm instead of rf[rs1]
- in_imm  in  32  immediate for A
- alu_f  out  3  to ALU F
- alu_a  out  32  to ALU A
- alu_b  out  32  to ALU B
- alu_r  in  32  from ALU R (combinational function of alu_f/a/b)
- out_valid  out  1  one-cycle result strobe
- out_rd  out  3  destination of strobed result
- out_data  out  32  result
- out_zero  out  1  out_data == 0
- out_neg  out  1  out_data[31]
- dbg_addr  in  3  debug read address
- dbg_data  out  32  combinational rf[dbg_addr]

## Operation
- States: IDLE, READ, EXEC, WB. in_ready = 1 in IDLE and WB, 0 in READ/EXEC and whenever rst = 1.
- Accept = in_valid & in_ready at a rising edge.
  - Latches op, rd, rs1, rs2, imm_en, imm.
  - Next state is READ.
- IDLE: no accept → stay in IDLE.
- READ → EXEC unconditionally:
  - alu_a <= imm_en ? imm : rf[rs1]
  - alu_b <= rf[rs2]
  - alu_f <= op
- EXEC → WB unconditionally:
  - out_data <= alu_r, out_rd <= rd
  - out_zero <= (alu_r == 0), out_neg <= alu_r[31]
- WB:
  - out_valid = 1 for exactly this cycle.
  - At the closing edge, rf[out_rd] <= out_data, except when out_rd = 0.
  - Next state is READ if an accept occurs at that edge, else IDLE.
- r0 reads as 0 always; writes to r0 are discarded. out_valid, out_data and flags still report the computed value.
- Write-then-read ordering: an instruction accepted in WB reads the register file at the following edge, so it sees the value just written. There is no forwarding or hazard logic.
- alu_f/a/b and out_data/out_rd/flags hold their last values between instructions.
- Arithmetic is modulo 2^32 and entirely inside the ALU. There is no carry/overflow flag.

## Timing
- Accept at edge E0:
  - alu_* valid after E1.
  - Result registered at E2; out_valid high in the cycle between E2 and E3.
  - Register file updated at E3.
- Back-to-back throughput: one instruction per 3 cycles (accept in WB). Isolated instruction: 4 cycles to return to IDLE.
- dbg_data is combinational. During WB it shows the old rf[out_rd]; from E3 onward it shows the new value.
- Reset (rst = 1 at an edge), from any state:
  - State → IDLE.
  - All rf entries, alu_f/a/b, out_data, out_rd, out_zero and out_neg → 0.
  - out_valid → 0.
  - An in-flight instruction is abandoned with no write-back.
  - An offer coincident with reset is not accepted.

## Test plan
- Reset then idle: after rst, dbg_data = 0 for all addresses, in_ready = 1, out_valid = 0, all alu_* = 0.
- Load immediates:
  - op 110, imm_en, imm 0x0000_0005 → r1. out_valid strobes in 3rd cycle after accept with out_data 5, zero 0, neg 0, and dbg r1 = 5 afterward.
  - Likewise 0xFFFF_FFFD → r2.
- Back-to-back dependency: with r1 = 5 and r2 = −3, issue add r3 = r1 + r2, then immediately (accept in WB) sub r4 = r3 − r1.
  - r3 = 2.
  - r4 = 0xFFFF_FFFD, neg = 1.
  - Accepts are exactly 3 cycles apart.
- Logic and zero flag:
  - xnor r5 = r1 xnor r1 → 0xFFFF_FFFF, neg = 1.
  - and r6 = r1 and r0 → 0, zero = 1.
  - not-B r7 with rs2 = r0 → 0xFFFF_FFFF.
- r0 protection: op 110, imm 0x1234 to rd 0 → out_data 0x1234 strobed, dbg r0 stays 0.
- Reset mid-operation: assert rst while in EXEC of a write to r3 → no out_valid, r3 = 0, state IDLE, in_ready = 1 the cycle after rst deasserts.
